// File: rtl/aib_tx_arbiter.sv
// Packet-aware round-robin arbiter sharing one AIB channel Tx bus among NUM_REQ requesters.
// A grant is held for a whole packet; beats reach the channel through one registered stage.
module aib_tx_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 72,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      i_bus_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        c_req_en,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]        i_req_last,
   output logic                      o_tx_valid,
   input  logic                      i_tx_ready,
   output logic [DATA_W-1:0]         o_tx_data,
   output logic [ID_W-1:0]           o_grant_id,
   output logic                      o_busy
);

   // Handshake: a beat moves from requester k when i_req_valid[k] & o_req_ready[k] at a
   // rising edge, and leaves the output stage when o_tx_valid & i_tx_ready at a rising edge.

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]         state_q;
   logic [ID_W-1:0]    ptr_q;
   logic [ID_W-1:0]    gnt_q;
   logic [ID_W-1:0]    grant_id_q;
   logic               busy_q;
   logic               tx_valid_q;
   logic [DATA_W-1:0]  tx_data_q;

   logic               can_accept;
   logic [NUM_REQ-1:0] cand;
   logic [ID_W-1:0]    win_idx;
   logic               win_found;
   logic [ID_W-1:0]    sel_idx;
   logic               sel_last;
   logic               beat_acc;
   logic [NUM_REQ-1:0] req_ready;
   logic [DATA_W-1:0]  req_beat [NUM_REQ];

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_beat
      assign req_beat[k] = i_req_data[k*DATA_W +: DATA_W];
   end

   assign can_accept = ~tx_valid_q | i_tx_ready;
   assign cand       = i_req_valid & c_req_en;

   // Search starts just past the last served requester and wraps once.
   always_comb begin
      logic [ID_W-1:0] idx;
      idx       = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = ID_W'((int'(ptr_q) + i) % NUM_REQ);
         if (!win_found && cand[idx]) begin
            win_found = 1'b1;
            win_idx   = idx;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (i_rst_n) begin
         if (state_q == ST_IDLE) begin
            if (can_accept && win_found) req_ready[win_idx] = 1'b1;
         end else begin
            req_ready[gnt_q] = can_accept;
         end
      end
   end

   assign sel_idx  = (state_q == ST_IDLE) ? win_idx : gnt_q;
   assign sel_last = i_req_last[sel_idx];
   assign beat_acc = |(i_req_valid & req_ready);

   always_ff @(posedge i_bus_clk) begin
      if (!i_rst_n) begin
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         state_q    <= ST_IDLE;
         ptr_q      <= ID_W'(NUM_REQ - 1);
         gnt_q      <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         if (beat_acc) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= req_beat[sel_idx];
         end else if (i_tx_ready) begin
            tx_valid_q <= 1'b0;
         end

         case (state_q)
            ST_IDLE: begin
               if (beat_acc) begin
                  grant_id_q <= win_idx;
                  if (sel_last) begin
                     ptr_q <= win_idx;
                  end else begin
                     state_q <= ST_LOCKED;
                     gnt_q   <= win_idx;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_LOCKED: begin
               // Enable is ignored here so a started packet always completes.
               if (beat_acc && sel_last) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= gnt_q;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_req_ready = req_ready;
   assign o_tx_valid  = tx_valid_q;
   assign o_tx_data   = tx_data_q;
   assign o_grant_id  = grant_id_q;
   assign o_busy      = busy_q;

endmodule
